mdu_seq: RTL



---
 rtl/mdu_seq_pkg.sv | 37 +++
 rtl/mdu_seq_calc.sv | 59 +++++
 rtl/mdu_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg -- shared definitions for the sequential multiply/divide unit.
//   mdu_op_e    : MDUOp encodings carried on the 4-bit op port
//   mdu_state_e : FSM states of mdu_seq
//   MDU_*_DEF   : default latencies for MULT/MULTU and DIV/DIVU
//   is_mult()   : true for the multiply ops (selects the latency)
//   is_div()    : true for the divide ops
package mdu_seq_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    localparam int unsigned MDU_MULT_CYC_DEF = 5;
    localparam int unsigned MDU_DIV_CYC_DEF  = 10;

    function automatic logic is_mult(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_seq_calc.sv
// mdu_calc -- combinational datapath producing the 64-bit {hi,lo} result
// of a latched MULT/MULTU/DIV/DIVU.
//   op_i  : latched MDUOp
//   a_i   : latched rs operand
//   b_i   : latched rt operand
//   res_o : {hi,lo} result
//   we_o  : result should be written to HI/LO
// Configuration: MDU_DIV0_HOLD_EN -- when defined, a divide by zero
// deasserts we_o so HI/LO keep their value; otherwise lo=all-ones, hi=a.
module mdu_calc
    import mdu_seq_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] res_o,
    output logic        we_o
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic        [63:0] a_zx;
    logic        [63:0] b_zx;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;

    // Operands are widened explicitly so the products are full 64-bit.
    assign a_sx = {{32{a_i[31]}}, a_i};
    assign b_sx = {{32{b_i[31]}}, b_i};
    assign a_zx = {32'd0, a_i};
    assign b_zx = {32'd0, b_i};
    assign a_s  = a_i;
    assign b_s  = b_i;

    always_comb begin
        res_o = '0;
        we_o  = 1'b1;
        case (op_i)
            MDU_MULT:  res_o = a_sx * b_sx;
            MDU_MULTU: res_o = a_zx * b_zx;
            MDU_DIV, MDU_DIVU: begin
                if (b_i == '0) begin
`ifdef MDU_DIV0_HOLD_EN
                    we_o  = 1'b0;
`else
                    res_o = {a_i, 32'hFFFF_FFFF};
`endif
                end else if (op_i == MDU_DIV) begin
                    // Signed / truncates toward zero; % takes the sign of a.
                    res_o = {a_s % b_s, a_s / b_s};
                end else begin
                    res_o = {a_i % b_i, a_i / b_i};
                end
            end
            default: we_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq -- multi-cycle MIPS-style multiply/divide unit with HI/LO.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   start : E-stage MULT/MULTU/DIV/DIVU
//   op    : E-stage MDUOp (mdu_seq_pkg encoding)
//   a, b  : E-stage rs / rt values
//   flush : E-stage instruction cancelled
//   d_use : D-stage instruction touches HI/LO
//   busy  : operation in flight
//   stall : freeze F/D, bubble into E
//   hi,lo : HI/LO registers
//   rd    : MFHI/MFLO read data for the E-stage op
// Configuration: MDU_DIV0_HOLD_EN (see mdu_calc) selects divide-by-zero
// behaviour.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int unsigned MULT_CYC = MDU_MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = MDU_DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        d_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd
);

    localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0]      res;
    logic             res_we;

    mdu_calc u_calc (
        .op_i  (op_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .res_o (res),
        .we_o  (res_we)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d = S_RUN;
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = is_mult(op) ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
                end else if (!flush && op == MDU_MTHI) begin
                    hi_d = a;
                end else if (!flush && op == MDU_MTLO) begin
                    lo_d = a;
                end
            end
            S_RUN: begin
                // start/flush are deliberately ignored here: the op has
                // already committed and finishes on the last counted edge.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (res_we) begin
                        hi_d = res[63:32];
                        lo_d = res[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy  = (state_q == S_RUN);
    assign stall = d_use & (busy | (start & ~flush));
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        rd = '0;
        if (op == MDU_MFHI) begin
            rd = hi_q;
        end else if (op == MDU_MFLO) begin
            rd = lo_q;
        end
    end

endmodule
